// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - DDS frequency sweep controller
// Steps a phase-increment word from start to stop, strobing each word into the DDS.
module dds_sweep_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        mode,
  input  logic [31:0] start_word,
  input  logic [31:0] stop_word,
  input  logic [31:0] step_word,
  input  logic [15:0] dwell,
  output logic [31:0] data,
  output logic        we,
  output logic        ce,
  output logic        busy,
  output logic        done,
  output logic        wrap
);

  typedef enum logic [1:0] {IDLE, LOAD, DWELL, DONE} state_t;

  state_t      state;
  logic [31:0] cfg_start;
  logic [31:0] cfg_stop;
  logic [31:0] cfg_step;
  logic [15:0] cfg_dwell;
  logic        cfg_mode;
  logic [15:0] cnt;

  logic [32:0] next_word;
  logic        sweep_end;
  logic        reload_ok;

  // data always holds the current word, so it doubles as the sweep accumulator.
  always_comb begin
    next_word = {1'b0, data} + {1'b0, cfg_step};
    sweep_end = (cfg_step == 32'd0) || (next_word > {1'b0, cfg_stop});
    reload_ok = cfg_mode && (cfg_step != 32'd0) && (cfg_start <= cfg_stop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cfg_start <= 32'd0;
      cfg_stop  <= 32'd0;
      cfg_step  <= 32'd0;
      cfg_dwell <= 16'd1;
      cfg_mode  <= 1'b0;
      cnt       <= 16'd0;
      data      <= 32'd0;
      we        <= 1'b0;
      ce        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      wrap <= 1'b0;
      if (abort) begin
        state <= IDLE;
        ce    <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              cfg_start <= start_word;
              cfg_stop  <= stop_word;
              cfg_step  <= step_word;
              cfg_dwell <= (dwell == 16'd0) ? 16'd1 : dwell;
              cfg_mode  <= mode;
              data      <= start_word;
              we        <= 1'b1;
              ce        <= 1'b1;
              busy      <= 1'b1;
              state     <= LOAD;
            end
          end
          LOAD: begin
            cnt   <= cfg_dwell - 16'd1;
            state <= DWELL;
          end
          DWELL: begin
            if (cnt != 16'd0) begin
              cnt <= cnt - 16'd1;
            end else if (!sweep_end) begin
              data  <= next_word[31:0];
              we    <= 1'b1;
              state <= LOAD;
            end else if (reload_ok) begin
              data  <= cfg_start;
              we    <= 1'b1;
              wrap  <= 1'b1;
              state <= LOAD;
            end else begin
              // ce stays high so the DDS keeps emitting the final frequency.
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - directed self-checking bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] start_word = '0;
  logic [31:0] stop_word = '0;
  logic [31:0] step_word = '0;
  logic [15:0] dwell = '0;
  logic [31:0] data;
  logic        we, ce, busy, done, wrap;

  dds_sweep_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .start_word(start_word), .stop_word(stop_word), .step_word(step_word),
    .dwell(dwell), .data(data), .we(we), .ce(ce), .busy(busy), .done(done),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          we_cyc[$];
  logic [31:0] we_data[$];
  logic        we_wrap[$];
  logic        we_busy[$];
  int          done_cyc[$];
  logic        done_busy[$];
  int          n_checks = 0;
  int          n_fail = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (we) begin
      we_cyc.push_back(cyc);
      we_data.push_back(data);
      we_wrap.push_back(wrap);
      we_busy.push_back(busy);
    end
    if (done) begin
      done_cyc.push_back(cyc);
      done_busy.push_back(busy);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    we_cyc.delete();
    we_data.delete();
    we_wrap.delete();
    we_busy.delete();
    done_cyc.delete();
    done_busy.delete();
  endtask

  task automatic kick(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                      input logic [15:0] d, input logic m);
    start_word = s;
    stop_word  = e;
    step_word  = st;
    dwell      = d;
    mode       = m;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cyc.size() == 0; i++) tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if ({data, we, ce, busy, done, wrap} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {data, we, ce, busy, done, wrap});
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({we, ce, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_release: got %b required 000", {we, ce, busy});
    end
  endtask

  task automatic test_single_sweep();
    logic [31:0] exp_w[4] = '{32'h1000, 32'h1100, 32'h1200, 32'h1300};
    clear_log();
    kick(32'h1000, 32'h1300, 32'h100, 16'd3, 1'b0);
    wait_done(60);
    n_checks++;
    if (done_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL single_done_count: got %0d required 1", done_cyc.size());
    end
    n_checks++;
    if (we_data.size() != 4) begin
      n_fail++;
      $display("FAIL single_word_count: got %0d required 4", we_data.size());
    end
    for (int i = 0; i < we_data.size() && i < 4; i++) begin
      n_checks++;
      if (we_data[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL single_word%0d: got %h required %h", i, we_data[i], exp_w[i]);
      end
    end
    for (int i = 1; i < we_cyc.size(); i++) begin
      n_checks++;
      if (we_cyc[i] - we_cyc[i-1] != 4) begin
        n_fail++;
        $display("FAIL single_spacing%0d: got %0d required 4", i, we_cyc[i] - we_cyc[i-1]);
      end
    end
    if (we_cyc.size() > 0 && done_cyc.size() > 0) begin
      n_checks++;
      if (done_cyc[0] - we_cyc[we_cyc.size()-1] != 4) begin
        n_fail++;
        $display("FAIL single_done_gap: got %0d required 4", done_cyc[0] - we_cyc[we_cyc.size()-1]);
      end
      n_checks++;
      if (done_busy[0] !== 1'b0 || we_busy[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL single_busy: got done-busy %b load-busy %b required 0 1", done_busy[0], we_busy[0]);
      end
    end
    tick();
    n_checks++;
    if ({ce, busy, data} !== {1'b1, 1'b0, 32'h1300}) begin
      n_fail++;
      $display("FAIL single_idle_hold: got ce %b busy %b data %h required 1 0 00001300", ce, busy, data);
    end
  endtask

  task automatic test_stop_not_hit();
    logic [31:0] exp_w[3] = '{32'h1000, 32'h1100, 32'h1200};
    clear_log();
    kick(32'h1000, 32'h1250, 32'h100, 16'd3, 1'b0);
    wait_done(60);
    n_checks++;
    if (we_data.size() != 3 || done_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL stop_counts: got words %0d dones %0d required 3 1", we_data.size(), done_cyc.size());
    end
    for (int i = 0; i < we_data.size() && i < 3; i++) begin
      n_checks++;
      if (we_data[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL stop_word%0d: got %h required %h", i, we_data[i], exp_w[i]);
      end
    end
    tick();
  endtask

  task automatic test_top_boundary();
    clear_log();
    kick(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd0, 1'b0);
    wait_done(30);
    n_checks++;
    if (we_data.size() != 2 || done_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL top_counts: got words %0d dones %0d required 2 1", we_data.size(), done_cyc.size());
    end
    if (we_data.size() == 2 && done_cyc.size() == 1) begin
      n_checks++;
      if (we_data[0] !== 32'hFFFF_FF00 || we_data[1] !== 32'hFFFF_FF80) begin
        n_fail++;
        $display("FAIL top_words: got %h %h required ffffff00 ffffff80", we_data[0], we_data[1]);
      end
      n_checks++;
      if (we_cyc[1] - we_cyc[0] != 2 || done_cyc[0] - we_cyc[1] != 2) begin
        n_fail++;
        $display("FAIL top_timing: got spacing %0d done gap %0d required 2 2",
                 we_cyc[1] - we_cyc[0], done_cyc[0] - we_cyc[1]);
      end
    end
    tick();
  endtask

  task automatic test_start_gt_stop();
    clear_log();
    kick(32'h5000, 32'h4000, 32'h10, 16'd2, 1'b0);
    wait_done(30);
    n_checks++;
    if (we_data.size() != 1 || done_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL inverted_counts: got words %0d dones %0d required 1 1", we_data.size(), done_cyc.size());
    end else begin
      n_checks++;
      if (we_data[0] !== 32'h5000 || done_cyc[0] - we_cyc[0] != 3) begin
        n_fail++;
        $display("FAIL inverted_word: got %h gap %0d required 00005000 3", we_data[0], done_cyc[0] - we_cyc[0]);
      end
    end
    tick();
  endtask

  task automatic test_continuous();
    logic [31:0] exp_w[6] = '{32'h1000, 32'h1100, 32'h1200, 32'h1300, 32'h1000, 32'h1100};
    logic        exp_r[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    clear_log();
    kick(32'h1000, 32'h1300, 32'h100, 16'd3, 1'b1);
    repeat (26) tick();
    n_checks++;
    if (we_data.size() < 6 || done_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL cont_counts: got words %0d dones %0d required >=6 0", we_data.size(), done_cyc.size());
    end
    for (int i = 0; i < we_data.size() && i < 6; i++) begin
      n_checks++;
      if (we_data[i] !== exp_w[i] || we_wrap[i] !== exp_r[i]) begin
        n_fail++;
        $display("FAIL cont_word%0d: got %h wrap %b required %h wrap %b", i, we_data[i], we_wrap[i], exp_w[i], exp_r[i]);
      end
    end
    for (int i = 1; i < we_cyc.size() && i < 6; i++) begin
      n_checks++;
      if (we_cyc[i] - we_cyc[i-1] != 4) begin
        n_fail++;
        $display("FAIL cont_spacing%0d: got %0d required 4", i, we_cyc[i] - we_cyc[i-1]);
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({busy, ce, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL cont_abort: got busy %b ce %b done %b required 000", busy, ce, done);
    end
  endtask

  task automatic test_abort();
    clear_log();
    kick(32'h1000, 32'h1300, 32'h100, 16'd3, 1'b0);
    for (int i = 0; i < 20 && we_data.size() < 2; i++) tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({busy, ce, we, done, wrap} !== 5'b00000) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b required 00000", {busy, ce, we, done, wrap});
    end
    n_checks++;
    if (data !== 32'h1100) begin
      n_fail++;
      $display("FAIL abort_data_hold: got %h required 00001100", data);
    end
    repeat (20) tick();
    n_checks++;
    if (done_cyc.size() != 0 || we_data.size() != 2) begin
      n_fail++;
      $display("FAIL abort_quiet: got dones %0d words %0d required 0 2", done_cyc.size(), we_data.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w[4] = '{32'h1000, 32'h1100, 32'h1200, 32'h1300};
    clear_log();
    kick(32'h1000, 32'h1300, 32'h100, 16'd3, 1'b0);
    tick();
    start_word = 32'h5000;
    step_word  = 32'h1;
    start      = 1'b1;
    tick();
    tick();
    start      = 1'b0;
    wait_done(60);
    repeat (6) tick();
    n_checks++;
    if (we_data.size() != 4 || done_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL b2b_counts: got words %0d dones %0d required 4 1", we_data.size(), done_cyc.size());
    end
    for (int i = 0; i < we_data.size() && i < 4; i++) begin
      n_checks++;
      if (we_data[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL b2b_word%0d: got %h required %h", i, we_data[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    clear_log();
    kick(32'h1000, 32'h1300, 32'h100, 16'd3, 1'b0);
    for (int i = 0; i < 20 && we_data.size() < 2; i++) tick();
    tick();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({data, we, ce, busy, done, wrap} !== 37'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h required 0", {data, we, ce, busy, done, wrap});
    end
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (done_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d required 0", done_cyc.size());
    end
    clear_log();
    kick(32'h2000, 32'h3000, 32'h0, 16'd5, 1'b0);
    wait_done(40);
    n_checks++;
    if (we_data.size() != 1 || done_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL zero_step_counts: got words %0d dones %0d required 1 1", we_data.size(), done_cyc.size());
    end else begin
      n_checks++;
      if (we_data[0] !== 32'h2000 || done_cyc[0] - we_cyc[0] != 6) begin
        n_fail++;
        $display("FAIL zero_step_word: got %h gap %0d required 00002000 6", we_data[0], done_cyc[0] - we_cyc[0]);
      end
    end
    repeat (3) tick();
    n_checks++;
    if ({ce, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL zero_step_ce: got ce %b busy %b required 1 0", ce, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_stop_not_hit();
    test_top_boundary();
    test_start_gt_stop();
    test_continuous();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
